virtio_mmio_regs: RTL
=====================

// Module: virtio_mmio_regs
// PURPOSE
//  AXI4-Lite slave implementing the virtio-mmio v2 (virtio 1.x) register file for one device with NUM_QUEUES virtqueues.
//  Sits between the CPU MMIO interconnect and a virtio device back-end (e.g. block device DMA engine).
//  Exports the negotiated queue layout, notify pulses and an interrupt line to the back-end.
// PARAMETERS
//  NUM_QUEUES     2             number of virtqueues (1..16)
//  QUEUE_NUM_MAX  8             max descriptors per queue; reported in QueueNumMax
//  DEVICE_ID      2             virtio device ID (2 = block)
//  VENDOR_ID      32'h554D4551  vendor ID register value
//  DEV_FEATURES   64'h1_0000_0000  device feature bits; VIRTIO_F_VERSION_1 set
// PORTS
//  clk            in   1   clock
//  rstn           in   1   reset: synchronous, active-low
//  axi_ar*/r*/aw*/w*/b*   AXI4-Lite slave, 32-bit addr/data; prot ignored
//  dev_qsel       in   $clog2(NUM_QUEUES)  queue index for the dev_q_* view
//  dev_q_desc     out  64  descriptor table address of dev_qsel
//  dev_q_avail    out  64  avail ring address
//  dev_q_used     out  64  used ring address
//  dev_q_num      out  16  queue size
//  dev_q_ready    out  1   QueueReady of dev_qsel
//  notify_valid   out  1   one-cycle pulse on a QueueNotify write
//  notify_queue   out  16  queue index written to QueueNotify
//  irq_used       in   1   pulse: set InterruptStatus[0]
//  irq_cfg        in   1   pulse: set InterruptStatus[1] and bump ConfigGeneration
//  irq            out  1   |InterruptStatus
//  dev_status     out  8   Status register
//  dev_reset      out  1   one-cycle pulse when the driver writes Status = 0
// BEHAVIOUR
//  Reset: arready = awready = wready = 1; rvalid = bvalid = 0; rdata = 0; resp = OKAY.
//   All registers are 0. notify_valid, dev_reset and irq are 0.
//  Read: AR accepted when arready. rvalid/rdata follow on the next cycle.
//   arready stays 0 until the R beat is taken (rvalid & rready); throughput is 1 read per 2 cycles.
//  Write: AW and W are latched independently. Each ready drops once its beat is held.
//   The write executes in the cycle both are held. bvalid rises on the next cycle.
//   Both readies return to 1 after the B beat is taken (bvalid & bready).
//  Read and write channels are independent and may complete in the same cycle.
//  Only wstrb == 4'hF writes modify state. Any other write is dropped and still returns B.
//  Register map (byte offsets):
//   000 Magic 0x74726976 | 004 Version 2 | 008 DeviceID | 00C VendorID
//   010 DeviceFeatures (word DevFeatSel) | 014 DevFeatSel | 020 DriverFeatures | 024 DrvFeatSel
//   030 QueueSel | 034 QueueNumMax | 038 QueueNum | 044 QueueReady | 050 QueueNotify (WO)
//   060 InterruptStatus (RO) | 064 InterruptACK (WO, W1C) | 070 Status | 0FC ConfigGeneration
//   080/084 QueueDesc lo/hi | 090/094 QueueAvail lo/hi | 0A0/0A4 QueueUsed lo/hi
//  QueueSel >= NUM_QUEUES: all per-queue reads return 0, including QueueNumMax; per-queue writes are ignored.
//  QueueNum write > QUEUE_NUM_MAX or 0: ignored. Feature selector > 1 reads 0.
//  Unmapped or WO reads return 0. Writes to RO or unmapped offsets are ignored.
//  irq_used/irq_cfg in the same cycle as an InterruptACK of the same bit: the set wins.
//  irq updates one cycle after a set or ACK.
//  Status = 0 write: clears queues, driver features, selectors and InterruptStatus;
//   pulses dev_reset the next cycle. ConfigGeneration is kept.
//  ConfigGeneration is 32 bits and wraps 0xFFFFFFFF -> 0.
//  rstn low mid-transaction: in-flight beats are dropped and state returns to reset values.
// CONFIGURATION
//  VIRTIO_MMIO_SLVERR_EN defined: unmapped offsets, misaligned addresses (addr[1:0] != 0) and partial-strobe writes
//   return resp = SLVERR (2'b10); reads also return rdata = 0.
//  Undefined: every access returns OKAY; behaviour is otherwise identical.
// STRUCTURE
//  Package virtio_pkg: register offset localparams, MAGIC/VERSION constants, InterruptStatus bit indices,
//   and the queue_cfg_t struct {desc, avail, used, num, ready}.
//  One sub-module: virtio_queue_bank (NUM_QUEUES x queue_cfg_t storage, with a CPU write/read port and the dev_qsel read port).
// TESTING
//  Read 0x000, 0x004, 0x008 -> 0x74726976, 2, 2; rvalid exactly one cycle after the AR handshake.
//  W beat 2 cycles before AW: QueueSel = 1, QueueNum = 8, QueueDesc lo = 0x8000_1000 -> dev_qsel = 1 shows num 8, desc 0x8000_1000.
//  QueueSel = 5 with NUM_QUEUES = 2 -> QueueNumMax reads 0; a QueueNum write leaves queues 0/1 unchanged.
//  irq_used pulse -> irq = 1, InterruptStatus = 1; ACK 1 coincident with a second pulse -> status stays 1.
//  Write 0x050 = 1 -> notify_valid for 1 cycle with notify_queue = 1; Status = 0 -> dev_reset pulse and queues cleared.
//  Read 0x200 and a wstrb = 4'h3 write -> SLVERR when VIRTIO_MMIO_SLVERR_EN is defined, OKAY/0 when not; rready held 0 for 3 cycles stalls arready.

Source files
------------

// File: rtl/virtio_pkg.sv
// rtl/virtio_pkg.sv - virtio-mmio v2 register offsets, constants and queue config type
// Purpose: shared definitions for virtio_mmio_regs and virtio_queue_bank.
// Contents: register byte offsets, MAGIC/VERSION values, AXI response codes,
//           InterruptStatus bit indices, queue_cfg_t, is_mapped() decode helper.
package virtio_pkg;

  localparam logic [31:0] VIRTIO_MAGIC   = 32'h7472_6976;
  localparam logic [31:0] VIRTIO_VERSION = 32'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] OFF_MAGIC          = 32'h000;
  localparam logic [31:0] OFF_VERSION        = 32'h004;
  localparam logic [31:0] OFF_DEVICE_ID      = 32'h008;
  localparam logic [31:0] OFF_VENDOR_ID      = 32'h00C;
  localparam logic [31:0] OFF_DEV_FEAT       = 32'h010;
  localparam logic [31:0] OFF_DEV_FEAT_SEL   = 32'h014;
  localparam logic [31:0] OFF_DRV_FEAT       = 32'h020;
  localparam logic [31:0] OFF_DRV_FEAT_SEL   = 32'h024;
  localparam logic [31:0] OFF_QUEUE_SEL      = 32'h030;
  localparam logic [31:0] OFF_QUEUE_NUM_MAX  = 32'h034;
  localparam logic [31:0] OFF_QUEUE_NUM      = 32'h038;
  localparam logic [31:0] OFF_QUEUE_READY    = 32'h044;
  localparam logic [31:0] OFF_QUEUE_NOTIFY   = 32'h050;
  localparam logic [31:0] OFF_INT_STATUS     = 32'h060;
  localparam logic [31:0] OFF_INT_ACK        = 32'h064;
  localparam logic [31:0] OFF_STATUS         = 32'h070;
  localparam logic [31:0] OFF_QUEUE_DESC_LO  = 32'h080;
  localparam logic [31:0] OFF_QUEUE_DESC_HI  = 32'h084;
  localparam logic [31:0] OFF_QUEUE_AVAIL_LO = 32'h090;
  localparam logic [31:0] OFF_QUEUE_AVAIL_HI = 32'h094;
  localparam logic [31:0] OFF_QUEUE_USED_LO  = 32'h0A0;
  localparam logic [31:0] OFF_QUEUE_USED_HI  = 32'h0A4;
  localparam logic [31:0] OFF_CONFIG_GEN     = 32'h0FC;

  localparam int ISR_USED_BIT = 0;
  localparam int ISR_CFG_BIT  = 1;

  typedef struct packed {
    logic [63:0] desc;
    logic [63:0] avail;
    logic [63:0] used;
    logic [15:0] num;
    logic        ready;
  } queue_cfg_t;

  // Full 32-bit compare: misaligned or out-of-window addresses never match.
  function automatic logic is_mapped(input logic [31:0] addr);
    case (addr)
      OFF_MAGIC, OFF_VERSION, OFF_DEVICE_ID, OFF_VENDOR_ID,
      OFF_DEV_FEAT, OFF_DEV_FEAT_SEL, OFF_DRV_FEAT, OFF_DRV_FEAT_SEL,
      OFF_QUEUE_SEL, OFF_QUEUE_NUM_MAX, OFF_QUEUE_NUM, OFF_QUEUE_READY,
      OFF_QUEUE_NOTIFY, OFF_INT_STATUS, OFF_INT_ACK, OFF_STATUS,
      OFF_QUEUE_DESC_LO, OFF_QUEUE_DESC_HI, OFF_QUEUE_AVAIL_LO,
      OFF_QUEUE_AVAIL_HI, OFF_QUEUE_USED_LO, OFF_QUEUE_USED_HI,
      OFF_CONFIG_GEN: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/virtio_queue_bank.sv
// rtl/virtio_queue_bank.sv - per-virtqueue configuration storage
// Purpose: NUM_QUEUES x queue_cfg_t registers with a CPU write/read port and a device view.
// Ports: clk, rstn (sync active-low); clr wipes every queue;
//        wr_en/wr_idx/wr_addr/wr_data: CPU write of a per-queue register;
//        rd_idx/rd_addr -> rd_data: CPU read of a per-queue register;
//        dev_qsel -> dev_cfg: back-end view of one queue.
module virtio_queue_bank
  import virtio_pkg::*;
#(
  parameter  int NUM_QUEUES    = 2,
  parameter  int QUEUE_NUM_MAX = 8,
  localparam int QW            = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [QW-1:0] wr_idx,
  input  logic [31:0]   wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [QW-1:0] rd_idx,
  input  logic [31:0]   rd_addr,
  output logic [31:0]   rd_data,
  input  logic [QW-1:0] dev_qsel,
  output queue_cfg_t    dev_cfg
);

  queue_cfg_t q [NUM_QUEUES];

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      for (int i = 0; i < NUM_QUEUES; i++) q[i] <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        // Sizes of 0 or above the maximum are refused, keeping the old size.
        OFF_QUEUE_NUM:
          if (wr_data != 32'd0 && wr_data <= 32'(QUEUE_NUM_MAX)) q[wr_idx].num <= wr_data[15:0];
        OFF_QUEUE_READY:    q[wr_idx].ready       <= wr_data[0];
        OFF_QUEUE_DESC_LO:  q[wr_idx].desc[31:0]  <= wr_data;
        OFF_QUEUE_DESC_HI:  q[wr_idx].desc[63:32] <= wr_data;
        OFF_QUEUE_AVAIL_LO: q[wr_idx].avail[31:0] <= wr_data;
        OFF_QUEUE_AVAIL_HI: q[wr_idx].avail[63:32] <= wr_data;
        OFF_QUEUE_USED_LO:  q[wr_idx].used[31:0]  <= wr_data;
        OFF_QUEUE_USED_HI:  q[wr_idx].used[63:32] <= wr_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      OFF_QUEUE_NUM_MAX:  rd_data = 32'(QUEUE_NUM_MAX);
      OFF_QUEUE_NUM:      rd_data = {16'd0, q[rd_idx].num};
      OFF_QUEUE_READY:    rd_data = {31'd0, q[rd_idx].ready};
      OFF_QUEUE_DESC_LO:  rd_data = q[rd_idx].desc[31:0];
      OFF_QUEUE_DESC_HI:  rd_data = q[rd_idx].desc[63:32];
      OFF_QUEUE_AVAIL_LO: rd_data = q[rd_idx].avail[31:0];
      OFF_QUEUE_AVAIL_HI: rd_data = q[rd_idx].avail[63:32];
      OFF_QUEUE_USED_LO:  rd_data = q[rd_idx].used[31:0];
      OFF_QUEUE_USED_HI:  rd_data = q[rd_idx].used[63:32];
      default:            rd_data = '0;
    endcase
  end

  assign dev_cfg = (int'(dev_qsel) < NUM_QUEUES) ? q[dev_qsel] : '0;

endmodule

// File: rtl/virtio_mmio_regs.sv
// rtl/virtio_mmio_regs.sv - AXI4-Lite virtio-mmio v2 register file for one device
// Purpose: CPU-facing virtio-mmio registers; exports queue layout, notify pulses and irq.
// Ports: clk, rstn (sync active-low); axi_ar*/r*/aw*/w*/b* AXI4-Lite slave (32-bit);
//        dev_qsel -> dev_q_desc/avail/used/num/ready; notify_valid/notify_queue;
//        irq_used/irq_cfg interrupt sources -> irq; dev_status; dev_reset pulse.
// Option: VIRTIO_MMIO_SLVERR_EN - unmapped, misaligned and partial-strobe accesses return SLVERR.
module virtio_mmio_regs
  import virtio_pkg::*;
#(
  parameter  int          NUM_QUEUES    = 2,
  parameter  int          QUEUE_NUM_MAX = 8,
  parameter  int          DEVICE_ID     = 2,
  parameter  logic [31:0] VENDOR_ID     = 32'h554D_4551,
  parameter  logic [63:0] DEV_FEATURES  = 64'h1_0000_0000,
  localparam int          QW            = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   axi_araddr,
  input  logic          axi_arvalid,
  output logic          axi_arready,
  output logic [31:0]   axi_rdata,
  output logic [1:0]    axi_rresp,
  output logic          axi_rvalid,
  input  logic          axi_rready,
  input  logic [31:0]   axi_awaddr,
  input  logic          axi_awvalid,
  output logic          axi_awready,
  input  logic [31:0]   axi_wdata,
  input  logic [3:0]    axi_wstrb,
  input  logic          axi_wvalid,
  output logic          axi_wready,
  output logic [1:0]    axi_bresp,
  output logic          axi_bvalid,
  input  logic          axi_bready,
  input  logic [QW-1:0] dev_qsel,
  output logic [63:0]   dev_q_desc,
  output logic [63:0]   dev_q_avail,
  output logic [63:0]   dev_q_used,
  output logic [15:0]   dev_q_num,
  output logic          dev_q_ready,
  output logic          notify_valid,
  output logic [15:0]   notify_queue,
  input  logic          irq_used,
  input  logic          irq_cfg,
  output logic          irq,
  output logic [7:0]    dev_status,
  output logic          dev_reset
);

  logic        aw_held, w_held;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic [31:0] dev_feat_sel, drv_feat_sel, queue_sel, config_gen;
  logic [63:0] drv_features;
  logic [1:0]  int_status, irq_set, irq_ack;
  logic [7:0]  status;
  logic        wr_exec, we, status_clr, q_valid;
  logic [31:0] rd_value, bank_rd_data;
  logic [1:0]  rd_resp, wr_resp;
  queue_cfg_t  dev_cfg;

  // Read channel: one outstanding beat; arready reopens once R is taken.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      axi_arready <= 1'b1;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= RESP_OKAY;
    end else if (axi_arvalid && axi_arready) begin
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b1;
      axi_rdata   <= rd_value;
      axi_rresp   <= rd_resp;
    end else if (axi_rvalid && axi_rready) begin
      axi_rvalid  <= 1'b0;
      axi_arready <= 1'b1;
    end
  end

  // Write channel: AW and W latch independently; bvalid marks the write done
  // so the held pair executes exactly once.
  assign axi_awready = ~aw_held;
  assign axi_wready  = ~w_held;
  assign wr_exec     = aw_held & w_held & ~axi_bvalid;
  assign we          = wr_exec & (w_strb_q == 4'hF);
  assign status_clr  = we && (aw_addr_q == OFF_STATUS) && (w_data_q[7:0] == 8'h00);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      axi_bvalid <= 1'b0;
      axi_bresp  <= RESP_OKAY;
    end else begin
      if (axi_awvalid && axi_awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= axi_awaddr;
      end
      if (axi_wvalid && axi_wready) begin
        w_held   <= 1'b1;
        w_data_q <= axi_wdata;
        w_strb_q <= axi_wstrb;
      end
      if (wr_exec) begin
        axi_bvalid <= 1'b1;
        axi_bresp  <= wr_resp;
      end else if (axi_bvalid && axi_bready) begin
        axi_bvalid <= 1'b0;
        aw_held    <= 1'b0;
        w_held     <= 1'b0;
      end
    end
  end

`ifdef VIRTIO_MMIO_SLVERR_EN
  assign rd_resp = is_mapped(axi_araddr) ? RESP_OKAY : RESP_SLVERR;
  assign wr_resp = (is_mapped(aw_addr_q) && w_strb_q == 4'hF) ? RESP_OKAY : RESP_SLVERR;
`else
  assign rd_resp = RESP_OKAY;
  assign wr_resp = RESP_OKAY;
`endif

  always_comb begin
    irq_set               = '0;
    irq_set[ISR_USED_BIT] = irq_used;
    irq_set[ISR_CFG_BIT]  = irq_cfg;
    irq_ack = (we && aw_addr_q == OFF_INT_ACK) ? w_data_q[1:0] : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      dev_feat_sel <= '0;
      drv_feat_sel <= '0;
      drv_features <= '0;
      queue_sel    <= '0;
      config_gen   <= '0;
      int_status   <= '0;
      status       <= '0;
      notify_valid <= 1'b0;
      notify_queue <= '0;
      dev_reset    <= 1'b0;
    end else begin
      notify_valid <= 1'b0;
      dev_reset    <= status_clr;
      if (irq_cfg) config_gen <= config_gen + 32'd1;
      // A source pulse always beats a same-cycle ACK or device reset.
      if (status_clr) int_status <= irq_set;
      else            int_status <= (int_status & ~irq_ack) | irq_set;
      if (status_clr) begin
        dev_feat_sel <= '0;
        drv_feat_sel <= '0;
        drv_features <= '0;
        queue_sel    <= '0;
        status       <= '0;
      end else if (we) begin
        case (aw_addr_q)
          OFF_DEV_FEAT_SEL: dev_feat_sel <= w_data_q;
          OFF_DRV_FEAT:
            if (drv_feat_sel == 32'd0)      drv_features[31:0]  <= w_data_q;
            else if (drv_feat_sel == 32'd1) drv_features[63:32] <= w_data_q;
          OFF_DRV_FEAT_SEL: drv_feat_sel <= w_data_q;
          OFF_QUEUE_SEL:    queue_sel    <= w_data_q;
          OFF_QUEUE_NOTIFY: begin
            notify_valid <= 1'b1;
            notify_queue <= w_data_q[15:0];
          end
          OFF_STATUS:       status <= w_data_q[7:0];
          default: ;
        endcase
      end
    end
  end

  assign q_valid = queue_sel < 32'(NUM_QUEUES);

  virtio_queue_bank #(
    .NUM_QUEUES    (NUM_QUEUES),
    .QUEUE_NUM_MAX (QUEUE_NUM_MAX)
  ) u_bank (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (status_clr),
    .wr_en    (we & q_valid),
    .wr_idx   (queue_sel[QW-1:0]),
    .wr_addr  (aw_addr_q),
    .wr_data  (w_data_q),
    .rd_idx   (queue_sel[QW-1:0]),
    .rd_addr  (axi_araddr),
    .rd_data  (bank_rd_data),
    .dev_qsel (dev_qsel),
    .dev_cfg  (dev_cfg)
  );

  always_comb begin
    rd_value = '0;
    case (axi_araddr)
      OFF_MAGIC:        rd_value = VIRTIO_MAGIC;
      OFF_VERSION:      rd_value = VIRTIO_VERSION;
      OFF_DEVICE_ID:    rd_value = 32'(DEVICE_ID);
      OFF_VENDOR_ID:    rd_value = VENDOR_ID;
      OFF_DEV_FEAT:
        if (dev_feat_sel == 32'd0)      rd_value = DEV_FEATURES[31:0];
        else if (dev_feat_sel == 32'd1) rd_value = DEV_FEATURES[63:32];
      OFF_DEV_FEAT_SEL: rd_value = dev_feat_sel;
      OFF_DRV_FEAT:
        if (drv_feat_sel == 32'd0)      rd_value = drv_features[31:0];
        else if (drv_feat_sel == 32'd1) rd_value = drv_features[63:32];
      OFF_DRV_FEAT_SEL: rd_value = drv_feat_sel;
      OFF_QUEUE_SEL:    rd_value = queue_sel;
      OFF_QUEUE_NUM_MAX, OFF_QUEUE_NUM, OFF_QUEUE_READY,
      OFF_QUEUE_DESC_LO, OFF_QUEUE_DESC_HI, OFF_QUEUE_AVAIL_LO,
      OFF_QUEUE_AVAIL_HI, OFF_QUEUE_USED_LO, OFF_QUEUE_USED_HI:
        if (q_valid) rd_value = bank_rd_data;
      OFF_INT_STATUS:   rd_value = {30'd0, int_status};
      OFF_STATUS:       rd_value = {24'd0, status};
      OFF_CONFIG_GEN:   rd_value = config_gen;
      default:          rd_value = '0;
    endcase
  end

  assign dev_q_desc  = dev_cfg.desc;
  assign dev_q_avail = dev_cfg.avail;
  assign dev_q_used  = dev_cfg.used;
  assign dev_q_num   = dev_cfg.num;
  assign dev_q_ready = dev_cfg.ready;
  assign irq         = |int_status;
  assign dev_status  = status;

endmodule
